// File: rtl/bcd_display_converter.sv
// Iterative binary-to-BCD converter (shift-add-3) with start/done handshake,
// held result registers, overflow saturation, leading-zero flags and
// per-digit seven-segment decode.
//
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   start, value      - conversion request and operand (sampled when accepted)
//   ready             - idle, a start will be accepted
//   done              - one-cycle pulse when a new result is loaded
//   overflow          - last operand was >= 10^DIGITS (result saturated to 9s)
//   bcd               - held result, digit i in [4i+3:4i], digit 0 = units
//   digit_blank       - bit i set when digit i is a leading zero (bit 0 never)
//   seg               - gfedcba active-high segments per digit, digit i at [7i+6:7i]
module bcd_display_converter #(
  parameter int unsigned WIDTH  = 15,
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    value,
  output logic                ready,
  output logic                done,
  output logic                overflow,
  output logic [4*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]   digit_blank,
  output logic [7*DIGITS-1:0] seg
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  sr, sr_n;
  logic [BW-1:0]     scratch, scratch_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              sticky, sticky_n;
  logic              ready_n, done_n, overflow_n;
  logic [BW-1:0]     bcd_n;
  logic [DIGITS-1:0] blank_n;

  logic [BW-1:0]     adj;
  logic [BW-1:0]     shifted;
  logic              carry;

  // Leading-zero flags: digit i is blank when it and every higher digit are 0.
  function automatic logic [DIGITS-1:0] blank_of(input logic [BW-1:0] b);
    logic zero_above;
    blank_of   = '0;
    zero_above = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_above  = zero_above & (b[4*i +: 4] == 4'd0);
      blank_of[i] = zero_above;
    end
  endfunction

  // Seven-segment decode, gfedcba active-high; non-decimal codes go dark.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h3F;
      4'd1:    seg_of = 7'h06;
      4'd2:    seg_of = 7'h5B;
      4'd3:    seg_of = 7'h4F;
      4'd4:    seg_of = 7'h66;
      4'd5:    seg_of = 7'h6D;
      4'd6:    seg_of = 7'h7D;
      4'd7:    seg_of = 7'h07;
      4'd8:    seg_of = 7'h7F;
      4'd9:    seg_of = 7'h6F;
      default: seg_of = 7'h00;
    endcase
  endfunction

  // Add-3 correction on every scratch digit that is 5 or more.
  always_comb begin
    adj = scratch;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (scratch[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
  end

  // A set MSB after correction would be lost by the shift: operand too large.
  assign carry   = adj[BW-1];
  assign shifted = {adj[BW-2:0], sr[WIDTH-1]};

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sr          <= '0;
      scratch     <= '0;
      cnt         <= '0;
      sticky      <= 1'b0;
      ready       <= 1'b1;
      done        <= 1'b0;
      overflow    <= 1'b0;
      bcd         <= '0;
      digit_blank <= BLANK_RST;
    end else begin
      state       <= state_n;
      sr          <= sr_n;
      scratch     <= scratch_n;
      cnt         <= cnt_n;
      sticky      <= sticky_n;
      ready       <= ready_n;
      done        <= done_n;
      overflow    <= overflow_n;
      bcd         <= bcd_n;
      digit_blank <= blank_n;
    end
  end

  // Next-state and output-load logic.
  always_comb begin
    state_n    = state;
    sr_n       = sr;
    scratch_n  = scratch;
    cnt_n      = cnt;
    sticky_n   = sticky;
    ready_n    = ready;
    done_n     = 1'b0;
    overflow_n = overflow;
    bcd_n      = bcd;
    blank_n    = digit_blank;
    case (state)
      IDLE: begin
        if (start) begin
          state_n   = SHIFT;
          sr_n      = value;
          scratch_n = '0;
          sticky_n  = 1'b0;
          cnt_n     = CW'(WIDTH);
          ready_n   = 1'b0;
        end
      end
      SHIFT: begin
        scratch_n = shifted;
        sr_n      = sr << 1;
        sticky_n  = sticky | carry;
        cnt_n     = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = IDLE;
          ready_n = 1'b1;
          done_n  = 1'b1;
          if (sticky | carry) begin
            bcd_n      = {DIGITS{4'h9}};
            overflow_n = 1'b1;
            blank_n    = '0;
          end else begin
            bcd_n      = shifted;
            overflow_n = 1'b0;
            blank_n    = blank_of(shifted);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Segment outputs follow the held result.
  always_comb begin
    seg = '0;
    for (int d = 0; d < int'(DIGITS); d++) seg[7*d +: 7] = seg_of(bcd[4*d +: 4]);
  end

endmodule

// File: tb/tb_bcd_display_converter.sv
// Self-checking bench for bcd_display_converter: default build plus three
// small parameter sets, checked against a div/mod reference model.
module tb_bcd_display_converter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Default build: WIDTH=15, DIGITS=4
  logic        start0 = 1'b0;
  logic [14:0] value0 = '0;
  logic        ready0, done0, ovf0;
  logic [15:0] bcd0;
  logic [3:0]  blank0;
  logic [27:0] seg0;

  // WIDTH=4, DIGITS=2
  logic        start1 = 1'b0;
  logic [3:0]  value1 = '0;
  logic        ready1, done1, ovf1;
  logic [7:0]  bcd1;
  logic [1:0]  blank1;
  logic [13:0] seg1;

  // WIDTH=8, DIGITS=2
  logic        start2 = 1'b0;
  logic [7:0]  value2 = '0;
  logic        ready2, done2, ovf2;
  logic [7:0]  bcd2;
  logic [1:0]  blank2;
  logic [13:0] seg2;

  // WIDTH=10, DIGITS=3
  logic        start3 = 1'b0;
  logic [9:0]  value3 = '0;
  logic        ready3, done3, ovf3;
  logic [11:0] bcd3;
  logic [2:0]  blank3;
  logic [20:0] seg3;

  bcd_display_converter #(.WIDTH(15), .DIGITS(4)) u0 (
    .clk(clk), .reset(reset), .start(start0), .value(value0), .ready(ready0),
    .done(done0), .overflow(ovf0), .bcd(bcd0), .digit_blank(blank0), .seg(seg0));
  bcd_display_converter #(.WIDTH(4), .DIGITS(2)) u1 (
    .clk(clk), .reset(reset), .start(start1), .value(value1), .ready(ready1),
    .done(done1), .overflow(ovf1), .bcd(bcd1), .digit_blank(blank1), .seg(seg1));
  bcd_display_converter #(.WIDTH(8), .DIGITS(2)) u2 (
    .clk(clk), .reset(reset), .start(start2), .value(value2), .ready(ready2),
    .done(done2), .overflow(ovf2), .bcd(bcd2), .digit_blank(blank2), .seg(seg2));
  bcd_display_converter #(.WIDTH(10), .DIGITS(3)) u3 (
    .clk(clk), .reset(reset), .start(start3), .value(value3), .ready(ready3),
    .done(done3), .overflow(ovf3), .bcd(bcd3), .digit_blank(blank3), .seg(seg3));

  int total = 0;
  int bad = 0;

  localparam logic [6:0] SEGTAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  typedef struct {
    logic [14:0] v;
    logic [15:0] b;
    logic [3:0]  bl;
    logic        o;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by div/mod, saturate when out of range,
  // digit i (i>=1) is a leading zero exactly when v < 10^i.
  function automatic void model(input longint v, input int digits,
                                output logic [35:0] b, output logic o,
                                output logic [8:0] bl);
    longint lim, t, p;
    lim = 1;
    for (int i = 0; i < digits; i++) lim *= 10;
    b = '0;
    bl = '0;
    o = (v >= lim);
    t = v;
    p = 10;
    for (int i = 0; i < digits; i++) begin
      b[4*i +: 4] = o ? 4'd9 : 4'(t % 10);
      t = t / 10;
    end
    for (int i = 1; i < digits; i++) begin
      bl[i] = !o && (v < p);
      p *= 10;
    end
  endfunction

  function automatic logic [27:0] seg_exp(input logic [15:0] b);
    logic [3:0] d;
    seg_exp = '0;
    for (int i = 0; i < 4; i++) begin
      d = b[4*i +: 4];
      seg_exp[7*i +: 7] = (d <= 4'd9) ? SEGTAB[d] : 7'h00;
    end
  endfunction

  function automatic logic sdone(input int w);
    return (w == 1) ? done1 : (w == 2) ? done2 : done3;
  endfunction

  // Start a conversion on u0 and wait for done; lat = rising edges after acceptance.
  task automatic conv0(input logic [14:0] v, output int lat);
    start0 = 1'b1;
    value0 = v;
    @(negedge clk);
    start0 = 1'b0;
    lat = 0;
    while (!done0 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("u0 done seen", 64'(done0), 64'd1);
  endtask

  task automatic conv_s(input int which, input int v, output logic [11:0] b,
                        output logic o, output logic [2:0] bl, output int lat);
    case (which)
      1:       begin start1 = 1'b1; value1 = 4'(v);  end
      2:       begin start2 = 1'b1; value2 = 8'(v);  end
      default: begin start3 = 1'b1; value3 = 10'(v); end
    endcase
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
    lat = 0;
    while (!sdone(which) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("small done seen", 64'(sdone(which)), 64'd1);
    case (which)
      1:       begin b = 12'(bcd1); o = ovf1; bl = 3'(blank1); end
      2:       begin b = 12'(bcd2); o = ovf2; bl = 3'(blank2); end
      default: begin b = bcd3;      o = ovf3; bl = blank3;      end
    endcase
  endtask

  task automatic check_u0(input logic [14:0] v);
    logic [35:0] mb;
    logic        mo;
    logic [8:0]  mbl;
    model(longint'(v), 4, mb, mo, mbl);
    check("u0 bcd", 64'(bcd0), 64'(mb[15:0]));
    check("u0 overflow", 64'(ovf0), 64'(mo));
    check("u0 blank", 64'(blank0), 64'(mbl[3:0]));
    check("u0 seg", 64'(seg0), 64'(seg_exp(mb[15:0])));
  endtask

  initial begin
    int lat;
    int pulses;
    int wid [4];
    int dig [4];
    logic [11:0] sb;
    logic        so;
    logic [2:0]  sbl;
    logic [35:0] mb;
    logic        mo;
    logic [8:0]  mbl;
    logic [15:0] prev;
    logic [14:0] rv;

    wid = '{15, 4, 8, 10};
    dig = '{4, 2, 2, 3};

    vecs[0] = '{v: 15'd1234,  b: 16'h1234, bl: 4'b0000, o: 1'b0};
    vecs[1] = '{v: 15'd9999,  b: 16'h9999, bl: 4'b0000, o: 1'b0};
    vecs[2] = '{v: 15'd10000, b: 16'h9999, bl: 4'b0000, o: 1'b1};
    vecs[3] = '{v: 15'd32767, b: 16'h9999, bl: 4'b0000, o: 1'b1};
    vecs[4] = '{v: 15'd0,     b: 16'h0000, bl: 4'b1110, o: 1'b0};
    vecs[5] = '{v: 15'd7,     b: 16'h0007, bl: 4'b1110, o: 1'b0};
    vecs[6] = '{v: 15'd305,   b: 16'h0305, bl: 4'b1000, o: 1'b0};
    vecs[7] = '{v: 15'd1000,  b: 16'h1000, bl: 4'b0000, o: 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst ready", 64'(ready0), 64'd1);
    check("rst done", 64'(done0), 64'd0);
    check("rst overflow", 64'(ovf0), 64'd0);
    check("rst bcd", 64'(bcd0), 64'd0);
    check("rst blank", 64'(blank0), 64'b1110);
    check("rst seg", 64'(seg0), 64'(seg_exp(16'h0000)));
    check("rst blank u3", 64'(blank3), 64'b110);
    check("rst blank u1", 64'(blank1), 64'b10);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      conv0(vecs[i].v, lat);
      check("tbl latency", 64'(lat), 64'd15);
      check("tbl bcd", 64'(bcd0), 64'(vecs[i].b));
      check("tbl blank", 64'(blank0), 64'(vecs[i].bl));
      check("tbl overflow", 64'(ovf0), 64'(vecs[i].o));
      check("tbl seg", 64'(seg0), 64'(seg_exp(vecs[i].b)));
      check("tbl ready at done", 64'(ready0), 64'd1);
      @(negedge clk);
      check("tbl done one cycle", 64'(done0), 64'd0);
    end

    // Random operands vs model
    repeat (40) begin
      rv = 15'($urandom_range(0, 32767));
      conv0(rv, lat);
      check("rnd latency", 64'(lat), 64'd15);
      check_u0(rv);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);

    // Handshake: start during SHIFT ignored, value change ignored, outputs held
    prev = bcd0;
    start0 = 1'b1;
    value0 = 15'd42;
    @(negedge clk);
    start0 = 1'b0;
    lat = 0;
    while (!done0 && lat < 100) begin
      check("hs ready low", 64'(ready0), 64'd0);
      check("hs bcd held", 64'(bcd0), 64'(prev));
      if (lat == 5) begin
        start0 = 1'b1;
        value0 = 15'd99;
      end else begin
        start0 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start0 = 1'b0;
    check("hs done seen", 64'(done0), 64'd1);
    check("hs latency", 64'(lat), 64'd15);
    check("hs bcd 42", 64'(bcd0), 64'h0042);
    check("hs blank 42", 64'(blank0), 64'b1100);
    // Back-to-back: start in the done cycle
    conv0(15'd56, lat);
    check("b2b latency", 64'(lat), 64'd15);
    check("b2b bcd", 64'(bcd0), 64'h0056);
    @(negedge clk);

    // Reset mid-conversion
    start0 = 1'b1;
    value0 = 15'd4321;
    @(negedge clk);
    start0 = 1'b0;
    repeat (7) @(negedge clk);
    check("pre-rst busy", 64'(ready0), 64'd0);
    reset = 1'b1;
    #1;
    check("mid rst ready", 64'(ready0), 64'd1);
    check("mid rst bcd", 64'(bcd0), 64'd0);
    check("mid rst blank", 64'(blank0), 64'b1110);
    check("mid rst seg", 64'(seg0), 64'(seg_exp(16'h0000)));
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (done0) pulses++;
    end
    check("no done after rst", 64'(pulses), 64'd0);
    check("bcd still 0 after rst", 64'(bcd0), 64'd0);

    // Parameter sweep corners
    conv_s(1, 15, sb, so, sbl, lat);
    check("w4 latency", 64'(lat), 64'd4);
    check("w4 bcd 15", 64'(sb), 64'h015);
    check("w4 ovf 15", 64'(so), 64'd0);
    @(negedge clk);
    conv_s(2, 100, sb, so, sbl, lat);
    check("w8 latency", 64'(lat), 64'd8);
    check("w8 bcd 100", 64'(sb), 64'h099);
    check("w8 ovf 100", 64'(so), 64'd1);
    check("w8 blank 100", 64'(sbl), 64'd0);
    @(negedge clk);

    // Exhaustive sweep on the small builds
    for (int w = 1; w <= 3; w++) begin
      for (int v = 0; v < (1 << wid[w]); v++) begin
        conv_s(w, v, sb, so, sbl, lat);
        model(longint'(v), dig[w], mb, mo, mbl);
        check("sweep latency", 64'(lat), 64'(wid[w]));
        check("sweep bcd", 64'(sb), 64'(mb[11:0]));
        check("sweep ovf", 64'(so), 64'(mo));
        check("sweep blank", 64'(sbl), 64'(mbl[2:0]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
